// File: rtl/tt_pad_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tt_pad_sequencer
//  Brief    : Host-side initiator for the tt_um_top pad interface. Takes one
//             operation per request handshake, drives the ui_in/uio_in pad
//             images, waits a programmable settle time, samples uo_out and
//             returns the captured byte on a valid/ready response channel.
//  Revision : 1.0  initial release
// ============================================================================
module tt_pad_sequencer #(
    parameter int SETTLE = 2,   // extra cycles after pads change before sampling
    parameter int CNT_W  = 8    // width of the completed-transaction counter
) (
    input  logic             clk,
    input  logic             rst,
    // request channel
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_sel,
    input  logic [5:0]       req_a,
    input  logic [5:0]       req_b,
    input  logic             req_cin,
    // response channel
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [1:0]       rsp_sel,
    output logic [7:0]       rsp_data,
    // pad side
    output logic [7:0]       pad_ui_in,
    output logic [7:0]       pad_uio_in,
    input  logic [7:0]       pad_uo_out,
    // statistics
    output logic [CNT_W-1:0] txn_count
);

    // Settle counter must hold SETTLE; keep at least one bit for SETTLE of 0 or 1.
    localparam int c_sw = (SETTLE < 2) ? 1 : $clog2(SETTLE + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [c_sw-1:0] r_cnt;
    logic            w_req_fire;
    logic            w_rsp_fire;
    logic            w_sample;

    // Ready is gated by rst so the host never sees an accept window while the
    // block is held in reset; it rises as soon as reset is released.
    assign req_ready = (r_state == S_IDLE) && !rst;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and per-cycle strobes for the datapath.
    always_comb begin
        w_state_nxt = r_state;
        w_req_fire  = 1'b0;
        w_rsp_fire  = 1'b0;
        w_sample    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (req_valid) begin
                    w_req_fire  = 1'b1;
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (r_cnt == '0) begin
                    w_sample    = 1'b1;
                    w_state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                // rsp_valid is always high in RESP, so rsp_ready alone completes it.
                if (rsp_ready) begin
                    w_rsp_fire  = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Pad images are registered at acceptance and held until the next accept,
    // so latch-style slots see stable inputs between operations.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pad_ui_in  <= 8'h00;
            pad_uio_in <= 8'h00;
        end else if (w_req_fire) begin
            pad_ui_in  <= {req_sel, req_a};
            pad_uio_in <= {req_cin, 1'b0, req_b};
        end
    end

    // Settle counter: loaded on accept, counts down while waiting.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (w_req_fire) begin
            r_cnt <= c_sw'(SETTLE);
        end else if ((r_state == S_WAIT) && (r_cnt != '0)) begin
            r_cnt <= r_cnt - c_sw'(1);
        end
    end

    // Response capture; data and select persist after the handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid <= 1'b0;
            rsp_sel   <= 2'b00;
            rsp_data  <= 8'h00;
        end else if (w_sample) begin
            rsp_valid <= 1'b1;
            rsp_sel   <= pad_ui_in[7:6];
            rsp_data  <= pad_uo_out;
        end else if (w_rsp_fire) begin
            rsp_valid <= 1'b0;
        end
    end

    // Completed-response counter; wraps naturally at 2^CNT_W.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            txn_count <= '0;
        end else if (w_rsp_fire) begin
            txn_count <= txn_count + CNT_W'(1);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_tt_pad_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_tt_pad_sequencer
//  Brief    : Self-checking bench for tt_pad_sequencer. Three instances with
//             different SETTLE/CNT_W share one clock; each drives a small
//             pad-side model whose output lags the pads by SETTLE cycles.
//  Revision : 1.0  initial release
// ============================================================================
module tb_tt_pad_sequencer;

    localparam int N_DUT = 3;

    typedef struct {
        int         k;
        logic [1:0] sel;
        logic [7:0] data;
        int         due;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    int         cyc = 0;
    int         total = 0;
    int         bad = 0;
    int         exp_cnt [N_DUT];
    exp_t       sb [$];

    logic       req_valid [N_DUT];
    logic       req_ready [N_DUT];
    logic [1:0] req_sel   [N_DUT];
    logic [5:0] req_a     [N_DUT];
    logic [5:0] req_b     [N_DUT];
    logic       req_cin   [N_DUT];
    logic       rsp_valid [N_DUT];
    logic       rsp_ready [N_DUT];
    logic [1:0] rsp_sel   [N_DUT];
    logic [7:0] rsp_data  [N_DUT];
    logic [7:0] pad_ui    [N_DUT];
    logic [7:0] pad_uio   [N_DUT];
    logic [7:0] pad_uo    [N_DUT];
    logic [7:0] txn_cnt   [N_DUT];

    always #5 clk = ~clk;

    // Edge counter: after rising edge E, cyc reads E.
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int st_of(input int k);
        return (k == 0) ? 2 : (k == 1) ? 0 : 5;
    endfunction

    function automatic int cw_of(input int k);
        return (k == 1) ? 2 : 8;
    endfunction

    // Behavioural stand-in for tt_um_top's uo_out as a function of its pads.
    function automatic logic [7:0] model_uo(input logic [7:0] ui, input logic [7:0] uio);
        case (ui[7:6])
            2'd0:    return {2'b00, ui[5:0]} + {2'b00, uio[5:0]} + {7'd0, uio[7]};
            2'd1:    return {2'b01, ui[5:0] & ~uio[5:0]};
            2'd2:    return {ui[5:0], 2'b10};
            default: return 8'h00;
        endcase
    endfunction

    for (genvar i = 0; i < N_DUT; i++) begin : g_dut
        localparam int P_ST = (i == 0) ? 2 : (i == 1) ? 0 : 5;
        localparam int P_CW = (i == 1) ? 2 : 8;
        logic [P_CW-1:0] tc;
        logic [7:0]      uo_now;

        assign uo_now     = model_uo(pad_ui[i], pad_uio[i]);
        assign txn_cnt[i] = 8'(tc);

        // Model output settles exactly one cycle before the sequencer samples it.
        if (P_ST == 0) begin : g_nodly
            assign pad_uo[i] = uo_now;
        end else begin : g_dly
            logic [7:0] dly [P_ST];
            always @(posedge clk) begin
                dly[0] <= uo_now;
                for (int j = 1; j < P_ST; j++) dly[j] <= dly[j-1];
            end
            assign pad_uo[i] = dly[P_ST-1];
        end

        tt_pad_sequencer #(.SETTLE(P_ST), .CNT_W(P_CW)) u_dut (
            .clk        (clk),
            .rst        (rst),
            .req_valid  (req_valid[i]),
            .req_ready  (req_ready[i]),
            .req_sel    (req_sel[i]),
            .req_a      (req_a[i]),
            .req_b      (req_b[i]),
            .req_cin    (req_cin[i]),
            .rsp_valid  (rsp_valid[i]),
            .rsp_ready  (rsp_ready[i]),
            .rsp_sel    (rsp_sel[i]),
            .rsp_data   (rsp_data[i]),
            .pad_ui_in  (pad_ui[i]),
            .pad_uio_in (pad_uio[i]),
            .pad_uo_out (pad_uo[i]),
            .txn_count  (tc)
        );
    end

    // One full transaction on instance k; optional backpressure hold and
    // optional asynchronous reset while the response is pending.
    task automatic do_txn(input int k, input logic [1:0] sel, input logic [5:0] a,
                          input logic [5:0] b, input logic cin, input int hold,
                          input bit abort);
        int   n;
        int   t;
        exp_t e;
        @(negedge clk);
        req_sel[k] = sel; req_a[k] = a; req_b[k] = b; req_cin[k] = cin;
        req_valid[k] = 1'b1;
        total++;
        if (req_ready[k] !== 1'b1) begin
            bad++; $display("FAIL ready_idle k=%0d got=%b want=1", k, req_ready[k]);
        end
        @(posedge clk); #1;
        n = cyc;
        sb.push_back('{k, sel, model_uo({sel, a}, {cin, 1'b0, b}), n + st_of(k) + 1});
        total++;
        if (pad_ui[k] !== {sel, a} || pad_uio[k] !== {cin, 1'b0, b}) begin
            bad++; $display("FAIL pads k=%0d got=%h/%h want=%h/%h", k, pad_ui[k], pad_uio[k],
                            {sel, a}, {cin, 1'b0, b});
        end
        @(negedge clk);
        req_valid[k] = 1'b0;
        t = 0;
        while (rsp_valid[k] !== 1'b1 && t < 30) begin @(negedge clk); t++; end
        e = sb.pop_front();
        total++;
        if (rsp_valid[k] !== 1'b1 || cyc != e.due) begin
            bad++; $display("FAIL latency k=%0d got valid=%b edge=%0d want edge=%0d", k,
                            rsp_valid[k], cyc, e.due);
        end
        total++;
        if (e.k != k || rsp_data[k] !== e.data || rsp_sel[k] !== e.sel) begin
            bad++; $display("FAIL rsp_data k=%0d got=%h/%0d want=%h/%0d", k, rsp_data[k],
                            rsp_sel[k], e.data, e.sel);
        end
        for (int h = 0; h < hold; h++) begin
            req_valid[k] = 1'b1; req_sel[k] = ~sel; req_a[k] = ~a; req_b[k] = ~b;
            @(negedge clk);
            total++;
            if (rsp_valid[k] !== 1'b1 || rsp_data[k] !== e.data || req_ready[k] !== 1'b0 ||
                pad_ui[k] !== {sel, a}) begin
                bad++; $display("FAIL hold k=%0d h=%0d got v=%b d=%h rdy=%b ui=%h want v=1 d=%h rdy=0 ui=%h",
                                k, h, rsp_valid[k], rsp_data[k], req_ready[k], pad_ui[k], e.data, {sel, a});
            end
        end
        req_valid[k] = 1'b0;
        if (abort) begin
            #2 rst = 1'b1;
            #1;
            total++;
            if (rsp_valid[k] !== 1'b0 || txn_cnt[k] !== 8'd0 || pad_ui[k] !== 8'd0 ||
                pad_uio[k] !== 8'd0 || req_ready[k] !== 1'b0) begin
                bad++; $display("FAIL async_rst k=%0d got v=%b cnt=%0d ui=%h uio=%h rdy=%b want all 0",
                                k, rsp_valid[k], txn_cnt[k], pad_ui[k], pad_uio[k], req_ready[k]);
            end
            for (int j = 0; j < N_DUT; j++) exp_cnt[j] = 0;
            @(negedge clk);
            rst = 1'b0;
            return;
        end
        rsp_ready[k] = 1'b1;
        @(posedge clk); #1;
        exp_cnt[k] = (exp_cnt[k] + 1) % (1 << cw_of(k));
        total++;
        if (rsp_valid[k] !== 1'b0 || txn_cnt[k] !== 8'(exp_cnt[k])) begin
            bad++; $display("FAIL handshake k=%0d got v=%b cnt=%0d want v=0 cnt=%0d", k,
                            rsp_valid[k], txn_cnt[k], exp_cnt[k]);
        end
        @(negedge clk);
        rsp_ready[k] = 1'b0;
        total++;
        if (req_ready[k] !== 1'b1 || rsp_data[k] !== e.data) begin
            bad++; $display("FAIL after_rsp k=%0d got rdy=%b d=%h want rdy=1 d=%h", k,
                            req_ready[k], rsp_data[k], e.data);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        for (int k = 0; k < N_DUT; k++) begin
            total++;
            if (pad_ui[k] !== 8'd0 || pad_uio[k] !== 8'd0 || rsp_valid[k] !== 1'b0 ||
                rsp_sel[k] !== 2'd0 || rsp_data[k] !== 8'd0 || txn_cnt[k] !== 8'd0 ||
                req_ready[k] !== 1'b0) begin
                bad++; $display("FAIL reset_vals k=%0d got ui=%h uio=%h v=%b sel=%0d d=%h cnt=%0d rdy=%b want 0",
                                k, pad_ui[k], pad_uio[k], rsp_valid[k], rsp_sel[k], rsp_data[k],
                                txn_cnt[k], req_ready[k]);
            end
        end
        rst = 1'b0;
        @(negedge clk);
        for (int k = 0; k < N_DUT; k++) begin
            total++;
            if (req_ready[k] !== 1'b1) begin
                bad++; $display("FAIL ready_release k=%0d got=%b want=1", k, req_ready[k]);
            end
        end
    endtask

    // SETTLE=0, CNT_W=2 instance: count sequence 1,2,3,0,1.
    task automatic test_wrap();
        for (int i = 0; i < 5; i++)
            do_txn(1, 2'(i), 6'(9 * i + 3), 6'(5 * i + 1), i[0], 0, 1'b0);
    endtask

    task automatic test_adder();
        do_txn(0, 2'd0, 6'd63, 6'd1,  1'b1, 0, 1'b0);
        do_txn(0, 2'd0, 6'd20, 6'd22, 1'b0, 0, 1'b0);
        do_txn(0, 2'd1, 6'h2D, 6'h0F, 1'b0, 0, 1'b0);
        do_txn(0, 2'd2, 6'h15, 6'h00, 1'b0, 0, 1'b0);
        do_txn(0, 2'd3, 6'h3F, 6'h3F, 1'b1, 0, 1'b0);
    endtask

    task automatic test_backpressure();
        do_txn(0, 2'd0, 6'd33, 6'd17, 1'b1, 10, 1'b0);
    endtask

    task automatic test_settle();
        do_txn(2, 2'd0, 6'd40, 6'd2,  1'b1, 0, 1'b0);
        do_txn(2, 2'd2, 6'h2A, 6'h01, 1'b0, 2, 1'b0);
        do_txn(1, 2'd0, 6'd10, 6'd12, 1'b1, 0, 1'b0);
        do_txn(1, 2'd1, 6'h3C, 6'h05, 1'b0, 0, 1'b0);
    endtask

    // Requests held continuously on instance 0: accepts spaced SETTLE+3 edges.
    task automatic test_back_to_back();
        int   prev;
        int   acc;
        int   t;
        exp_t e;
        logic [1:0] sel;
        logic [5:0] a;
        logic [5:0] b;
        prev = 0;
        rsp_ready[0] = 1'b1;
        for (int op = 0; op < 3; op++) begin
            t = 0;
            @(negedge clk);
            while (req_ready[0] !== 1'b1 && t < 20) begin @(negedge clk); t++; end
            if (op > 0) begin
                total++;
                if (txn_cnt[0] !== 8'(exp_cnt[0])) begin
                    bad++; $display("FAIL b2b_cnt op=%0d got=%0d want=%0d", op, txn_cnt[0], exp_cnt[0]);
                end
            end
            sel = 2'(op); a = 6'(op * 11 + 5); b = 6'(op * 7 + 2);
            req_sel[0] = sel; req_a[0] = a; req_b[0] = b; req_cin[0] = 1'b1;
            req_valid[0] = 1'b1;
            @(posedge clk); #1;
            acc = cyc;
            sb.push_back('{0, sel, model_uo({sel, a}, {1'b1, 1'b0, b}), acc + st_of(0) + 1});
            if (op > 0) begin
                total++;
                if (acc - prev != st_of(0) + 3) begin
                    bad++; $display("FAIL b2b_spacing op=%0d got=%0d want=%0d", op, acc - prev, st_of(0) + 3);
                end
            end
            prev = acc;
            t = 0;
            @(negedge clk);
            while (rsp_valid[0] !== 1'b1 && t < 20) begin @(negedge clk); t++; end
            e = sb.pop_front();
            total++;
            if (rsp_valid[0] !== 1'b1 || cyc != e.due || rsp_data[0] !== e.data || rsp_sel[0] !== e.sel) begin
                bad++; $display("FAIL b2b_rsp op=%0d got v=%b edge=%0d d=%h sel=%0d want edge=%0d d=%h sel=%0d",
                                op, rsp_valid[0], cyc, rsp_data[0], rsp_sel[0], e.due, e.data, e.sel);
            end
            exp_cnt[0] = (exp_cnt[0] + 1) % 256;
        end
        req_valid[0] = 1'b0;
        @(posedge clk); #1;
        total++;
        if (rsp_valid[0] !== 1'b0 || txn_cnt[0] !== 8'(exp_cnt[0])) begin
            bad++; $display("FAIL b2b_end got v=%b cnt=%0d want v=0 cnt=%0d", rsp_valid[0], txn_cnt[0], exp_cnt[0]);
        end
        @(negedge clk);
        rsp_ready[0] = 1'b0;
    endtask

    task automatic test_reset_mid_resp();
        do_txn(0, 2'd0, 6'd12, 6'd30, 1'b0, 3, 1'b1);
        do_txn(0, 2'd0, 6'd63, 6'd1, 1'b1, 0, 1'b0);
    endtask

    initial begin
        for (int k = 0; k < N_DUT; k++) begin
            req_valid[k] = 1'b0; req_sel[k] = 2'd0; req_a[k] = 6'd0;
            req_b[k] = 6'd0; req_cin[k] = 1'b0; rsp_ready[k] = 1'b0; exp_cnt[k] = 0;
        end
        test_reset();
        test_wrap();
        test_adder();
        test_backpressure();
        test_settle();
        test_back_to_back();
        test_reset_mid_resp();
        total++;
        if (sb.size() != 0) begin
            bad++; $display("FAIL scoreboard_left got=%0d want=0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got=timeout want=finish");
        $fatal(1, "bench timeout");
    end

endmodule
`default_nettype wire
